// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the D-memory load/store unit: access sizes,
// byte-lane masks, FSM state encoding and the latched request record.
package riscv_lsu_pkg;

    // Access size encodings as presented on REQ_SIZE
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Right-aligned byte-lane masks for each size
    localparam logic [3:0] LM_B = 4'b0001;
    localparam logic [3:0] LM_H = 4'b0011;
    localparam logic [3:0] LM_W = 4'b1111;

    // Access sequencer states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC1 = 3'd1,
        ACC2 = 3'd2,
        CAP  = 3'd3,
        RESP = 3'd4
    } lsu_state_e;

    // Fields of an accepted request that outlive the accept cycle
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
        logic        split;
        logic [3:0]  mask_hi;
        logic [31:0] img_hi;
    } lsu_req_t;

    // Size code 11 is handled as a full word
    function automatic logic [3:0] lane_mask(input logic [1:0] size);
        case (size)
            SZ_B:    lane_mask = LM_B;
            SZ_H:    lane_mask = LM_H;
            default: lane_mask = LM_W;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Byte-lane alignment for the LSU: builds the two-word lane mask and write
// image for stores, and extracts/extends load data from a two-word window.
module dmem_lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic [1:0]  wr_size,
    input  logic [1:0]  wr_off,
    input  logic [31:0] wr_data,
    output logic [7:0]  wr_mask,
    output logic [63:0] wr_image,
    input  logic [1:0]  rd_size,
    input  logic [1:0]  rd_off,
    input  logic        rd_uns,
    input  logic [63:0] rd_words,
    output logic [31:0] rd_data
);

    logic [31:0] rd_sh;

    // Shift store mask/data into place across two words; shift load data down and extend
    always_comb begin
        wr_mask  = {4'b0000, lane_mask(wr_size)} << wr_off;
        wr_image = {32'd0, wr_data} << {wr_off, 3'b000};
        rd_sh    = 32'(rd_words >> {rd_off, 3'b000});
        case (rd_size)
            SZ_B:    rd_data = {{24{~rd_uns & rd_sh[7]}}, rd_sh[7:0]};
            SZ_H:    rd_data = {{16{~rd_uns & rd_sh[15]}}, rd_sh[15:0]};
            default: rd_data = rd_sh;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the MEM stage and the single-port data SRAM.
// One request per handshake; accesses crossing a word boundary take two
// SRAM cycles. All MEM_* and RSP_* outputs come straight from flops.
module dmem_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int AWIDTH = 12
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WE,
    input  logic [1:0]        REQ_SIZE,
    input  logic              REQ_UNSIGNED,
    input  logic [31:0]       REQ_ADDR,
    input  logic [31:0]       REQ_WDATA,
    output logic              RSP_VALID,
    output logic [31:0]       RSP_RDATA,
    output logic              RSP_ERR,
    output logic              MEM_CSN,
    output logic              MEM_WEN,
    output logic [AWIDTH-1:0] MEM_ADDR,
    output logic [3:0]        MEM_BE,
    output logic [31:0]       MEM_DI,
    input  logic [31:0]       MEM_DOUT
);

    lsu_state_e        state;
    lsu_req_t          req_q;
    logic [31:0]       lo_q;

    logic [7:0]        wr_mask;
    logic [63:0]       wr_image;
    logic [63:0]       rd_words;
    logic [31:0]       rd_data;
    logic [AWIDTH-1:0] req_word;
    logic              req_split;
    logic              req_err;

    assign REQ_READY = (state == IDLE);

    // Word index, split detection and range check for the request on the port
    always_comb begin
        req_word  = REQ_ADDR[AWIDTH+1:2];
        req_split = |wr_mask[7:4];
        // No wrap from the top word back to word 0
        req_err   = ((REQ_ADDR >> (AWIDTH + 2)) != 32'd0) ||
                    (req_split && (req_word == {AWIDTH{1'b1}}));
    end

    // In CAP the second (or only) read word is on MEM_DOUT; the first word of a
    // split load was parked in lo_q during ACC2
    always_comb begin
        if (req_q.split) rd_words = {MEM_DOUT, lo_q};
        else             rd_words = {32'd0, MEM_DOUT};
    end

    dmem_lsu_align u_align (
        .wr_size  (REQ_SIZE),
        .wr_off   (REQ_ADDR[1:0]),
        .wr_data  (REQ_WDATA),
        .wr_mask  (wr_mask),
        .wr_image (wr_image),
        .rd_size  (req_q.size),
        .rd_off   (req_q.off),
        .rd_uns   (req_q.uns),
        .rd_words (rd_words),
        .rd_data  (rd_data)
    );

    // Access sequencer with registered SRAM and response outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            req_q     <= '0;
            lo_q      <= '0;
            MEM_CSN   <= 1'b1;
            MEM_WEN   <= 1'b1;
            MEM_BE    <= 4'b0000;
            MEM_ADDR  <= '0;
            MEM_DI    <= '0;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= '0;
            RSP_ERR   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (REQ_VALID) begin
                        req_q.we      <= REQ_WE;
                        req_q.size    <= REQ_SIZE;
                        req_q.uns     <= REQ_UNSIGNED;
                        req_q.off     <= REQ_ADDR[1:0];
                        req_q.split   <= req_split;
                        req_q.mask_hi <= wr_mask[7:4];
                        req_q.img_hi  <= wr_image[63:32];
                        if (req_err) begin
                            // Out-of-range: answer immediately, never touch the SRAM
                            state     <= RESP;
                            RSP_VALID <= 1'b1;
                            RSP_ERR   <= 1'b1;
                            RSP_RDATA <= '0;
                        end else begin
                            state    <= ACC1;
                            MEM_CSN  <= 1'b0;
                            MEM_WEN  <= ~REQ_WE;
                            MEM_ADDR <= req_word;
                            MEM_BE   <= wr_mask[3:0];
                            MEM_DI   <= wr_image[31:0];
                        end
                    end
                end
                ACC1: begin
                    if (req_q.split) begin
                        // Second word of a split access; WEN carries over
                        state    <= ACC2;
                        MEM_CSN  <= 1'b0;
                        MEM_ADDR <= MEM_ADDR + 1'b1;
                        MEM_BE   <= req_q.mask_hi;
                        MEM_DI   <= req_q.img_hi;
                    end else begin
                        MEM_CSN <= 1'b1;
                        MEM_WEN <= 1'b1;
                        MEM_BE  <= 4'b0000;
                        if (!req_q.we) begin
                            state <= CAP;
                        end else begin
                            state     <= RESP;
                            RSP_VALID <= 1'b1;
                            RSP_ERR   <= 1'b0;
                            RSP_RDATA <= '0;
                        end
                    end
                end
                ACC2: begin
                    MEM_CSN <= 1'b1;
                    MEM_WEN <= 1'b1;
                    MEM_BE  <= 4'b0000;
                    if (!req_q.we) begin
                        // Read data of the first word arrives now
                        lo_q  <= MEM_DOUT;
                        state <= CAP;
                    end else begin
                        state     <= RESP;
                        RSP_VALID <= 1'b1;
                        RSP_ERR   <= 1'b0;
                        RSP_RDATA <= '0;
                    end
                end
                CAP: begin
                    state     <= RESP;
                    RSP_VALID <= 1'b1;
                    RSP_ERR   <= 1'b0;
                    RSP_RDATA <= rd_data;
                end
                RESP: begin
                    state     <= IDLE;
                    RSP_VALID <= 1'b0;
                    RSP_ERR   <= 1'b0;
                    RSP_RDATA <= '0;
                end
                default: begin
                    state   <= IDLE;
                    MEM_CSN <= 1'b1;
                    MEM_WEN <= 1'b1;
                    MEM_BE  <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu with a behavioural single-port SRAM.
module tb_dmem_lsu;

    localparam int AW = 12;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          REQ_VALID = 1'b0;
    logic          REQ_READY;
    logic          REQ_WE = 1'b0;
    logic [1:0]    REQ_SIZE = 2'b00;
    logic          REQ_UNSIGNED = 1'b0;
    logic [31:0]   REQ_ADDR = '0;
    logic [31:0]   REQ_WDATA = '0;
    logic          RSP_VALID;
    logic [31:0]   RSP_RDATA;
    logic          RSP_ERR;
    logic          MEM_CSN;
    logic          MEM_WEN;
    logic [AW-1:0] MEM_ADDR;
    logic [3:0]    MEM_BE;
    logic [31:0]   MEM_DI;
    logic [31:0]   MEM_DOUT;

    dmem_lsu #(.AWIDTH(AW)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_SIZE(REQ_SIZE), .REQ_UNSIGNED(REQ_UNSIGNED), .REQ_ADDR(REQ_ADDR),
        .REQ_WDATA(REQ_WDATA), .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA),
        .RSP_ERR(RSP_ERR), .MEM_CSN(MEM_CSN), .MEM_WEN(MEM_WEN),
        .MEM_ADDR(MEM_ADDR), .MEM_BE(MEM_BE), .MEM_DI(MEM_DI), .MEM_DOUT(MEM_DOUT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // SRAM model: zero-initialised, byte-masked writes, registered reads
    logic [31:0] mem [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    always @(posedge CLK) begin
        if (!MEM_CSN) begin
            if (!MEM_WEN) begin
                for (int b = 0; b < 4; b++)
                    if (MEM_BE[b]) mem[MEM_ADDR][8*b +: 8] <= MEM_DI[8*b +: 8];
            end else begin
                MEM_DOUT <= mem[MEM_ADDR];
            end
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every response is matched against the oldest expectation
    always @(negedge CLK) begin
        exp_t e;
        if (!RST && RSP_VALID) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got RSP_VALID=1 expected 0 (rdata 0x%08h)", RSP_RDATA);
            end else begin
                e = exp_q.pop_front();
                chk({e.name, "_rdata"}, RSP_RDATA, e.rdata);
                chk({e.name, "_err"}, {31'd0, RSP_ERR}, {31'd0, e.err});
                chk({e.name, "_lat"}, cyc, e.cyc);
            end
        end
    end

    // Drive a request from a falling edge, wait (bounded) for READY, queue the expectation.
    // REQ_VALID is left high so a following call forms a back-to-back pair.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_err, input int lat,
                         input string nm, output int c0, output int waited);
        exp_t e;
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_WE = we; REQ_SIZE = sz; REQ_UNSIGNED = uns;
        REQ_ADDR = addr; REQ_WDATA = wdata;
        waited = 0;
        while (!REQ_READY && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        c0 = cyc;
        if (!REQ_READY) begin
            checks++;
            failures++;
            $display("FAIL %s_accept: got READY=0 expected 1 within 20 cycles", nm);
        end else begin
            e.rdata = exp_rd; e.err = exp_err; e.cyc = c0 + lat; e.name = nm;
            exp_q.push_back(e);
        end
        @(posedge CLK);
        #1;
    endtask

    // Deassert the request and let all queued responses arrive (bounded)
    task automatic drain(input string nm);
        REQ_VALID = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: got %0d pending responses expected 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, w;

        // Reset values while RST is held
        repeat (2) @(negedge CLK);
        chk("rst_csn",   {31'd0, MEM_CSN},   32'd1);
        chk("rst_wen",   {31'd0, MEM_WEN},   32'd1);
        chk("rst_be",    {28'd0, MEM_BE},    32'd0);
        chk("rst_addr",  {20'd0, MEM_ADDR},  32'd0);
        chk("rst_di",    MEM_DI,             32'd0);
        chk("rst_valid", {31'd0, RSP_VALID}, 32'd0);
        chk("rst_rdata", RSP_RDATA,          32'd0);
        chk("rst_err",   {31'd0, RSP_ERR},   32'd0);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_ready", {31'd0, REQ_READY}, 32'd1);

        // 1: aligned word store and load
        issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2, "sw_al", c0, w);
        chk("sw_al_t1_csn",  {31'd0, MEM_CSN},  32'd0);
        chk("sw_al_t1_wen",  {31'd0, MEM_WEN},  32'd0);
        chk("sw_al_t1_addr", {20'd0, MEM_ADDR}, 32'h040);
        chk("sw_al_t1_be",   {28'd0, MEM_BE},   32'hF);
        chk("sw_al_t1_di",   MEM_DI,            32'hDEADBEEF);
        chk("sw_al_t1_ready", {31'd0, REQ_READY}, 32'd0);
        drain("sw_al");
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 3, "lw_al", c0, w);
        drain("lw_al");

        // 2: sign and zero extension
        issue(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'hFFFFFFBE, 1'b0, 3, "lb", c0, w);
        drain("lb");
        issue(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'h000000BE, 1'b0, 3, "lbu", c0, w);
        drain("lbu");
        issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'hFFFFDEAD, 1'b0, 3, "lh", c0, w);
        drain("lh");
        issue(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h0000DEAD, 1'b0, 3, "lhu", c0, w);
        drain("lhu");

        // 4: range errors, no SRAM access
        issue(1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 32'h0, 1'b1, 1, "err_hi", c0, w);
        chk("err_hi_csn", {31'd0, MEM_CSN}, 32'd1);
        drain("err_hi");
        issue(1'b0, 2'b10, 1'b0, 32'h3FFE, 32'h0, 32'h0, 1'b1, 1, "err_top", c0, w);
        chk("err_top_csn", {31'd0, MEM_CSN}, 32'd1);
        drain("err_top");

        // 5: reset during ACC2 of a split store
        issue(1'b1, 2'b10, 1'b0, 32'h203, 32'h11223344, 32'h0, 1'b0, 3, "rst_split", c0, w);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        exp_q.delete();
        REQ_VALID = 1'b0;
        chk("mid_rst_csn",   {31'd0, MEM_CSN},   32'd1);
        chk("mid_rst_wen",   {31'd0, MEM_WEN},   32'd1);
        chk("mid_rst_be",    {28'd0, MEM_BE},    32'd0);
        chk("mid_rst_addr",  {20'd0, MEM_ADDR},  32'd0);
        chk("mid_rst_di",    MEM_DI,             32'd0);
        chk("mid_rst_valid", {31'd0, RSP_VALID}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("mid_rst_ready", {31'd0, REQ_READY}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("mid_rst_no_rsp", {31'd0, RSP_VALID}, 32'd0);
        end
        issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h44000000, 1'b0, 3, "rst_w80", c0, w);
        drain("rst_w80");
        issue(1'b0, 2'b10, 1'b0, 32'h204, 32'h0, 32'h00000000, 1'b0, 3, "rst_w81", c0, w);
        drain("rst_w81");

        // 3: split store and load
        issue(1'b1, 2'b10, 1'b0, 32'h203, 32'h11223344, 32'h0, 1'b0, 3, "sw_sp", c0, w);
        chk("sw_sp_t1_addr", {20'd0, MEM_ADDR}, 32'h080);
        chk("sw_sp_t1_be",   {28'd0, MEM_BE},   32'h8);
        chk("sw_sp_t1_di",   MEM_DI,            32'h44000000);
        @(posedge CLK);
        #1;
        chk("sw_sp_t2_csn",  {31'd0, MEM_CSN},  32'd0);
        chk("sw_sp_t2_addr", {20'd0, MEM_ADDR}, 32'h081);
        chk("sw_sp_t2_be",   {28'd0, MEM_BE},   32'h7);
        chk("sw_sp_t2_di",   MEM_DI,            32'h00112233);
        drain("sw_sp");
        issue(1'b0, 2'b10, 1'b0, 32'h203, 32'h0, 32'h11223344, 1'b0, 4, "lw_sp", c0, w);
        drain("lw_sp");

        // 6: back-to-back SW then LW with REQ_VALID held high
        issue(1'b1, 2'b10, 1'b0, 32'h300, 32'h5A5A1234, 32'h0, 1'b0, 2, "b2b_sw", c0, w);
        issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h5A5A1234, 1'b0, 3, "b2b_lw", c1, w);
        chk("b2b_busy_cycles", w, 32'd2);
        chk("b2b_accept_gap", c1 - c0, 32'd3);
        drain("b2b");

        // Byte store into the top lane, then signed/unsigned byte loads
        issue(1'b1, 2'b00, 1'b0, 32'h107, 32'h123456A5, 32'h0, 1'b0, 2, "sb", c0, w);
        drain("sb");
        issue(1'b0, 2'b00, 1'b0, 32'h107, 32'h0, 32'hFFFFFFA5, 1'b0, 3, "lb_top", c0, w);
        drain("lb_top");
        issue(1'b0, 2'b00, 1'b1, 32'h107, 32'h0, 32'h000000A5, 1'b0, 3, "lbu_top", c0, w);
        drain("lbu_top");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit between the core's MEM stage and the single-port data SRAM (`SP_SRAM`, D-memory instance). It accepts one byte, half or word request per handshake and drives word-addressed SRAM accesses with active-low chip-select and write-enable. It generates byte enables and sign- or zero-extends loads. Accesses that cross a word boundary are split into two SRAM cycles.

## Interface
Parameters:
- `AWIDTH`, default 12. SRAM word-address width; the addressable range is 4·2^AWIDTH bytes.

Ports:
- `CLK`  in  1  system clock; all state on rising edge
- `RST`  in  1  asynchronous, active-high reset
- `REQ_VALID`  in  1  request present
- `REQ_READY`  out  1  request accepted when VALID&READY
- `REQ_WE`  in  1  1 = store, 0 = load
- `REQ_SIZE`  in  2  00 byte, 01 half, 10 word; 11 is treated as word
- `REQ_UNSIGNED`  in  1  zero-extend load (LBU/LHU)
- `REQ_ADDR`  in  32  byte address
- `REQ_WDATA`  in  32  store data, right-aligned
- `RSP_VALID`  out  1  one-cycle completion pulse
- `RSP_RDATA`  out  32  extended load data; 0 for stores and errors
- `RSP_ERR`  out  1  out-of-range access, qualified by RSP_VALID
- `MEM_CSN`  out  1  SRAM chip select, active low
- `MEM_WEN`  out  1  SRAM write enable, active low
- `MEM_ADDR`  out  AWIDTH  SRAM word address
- `MEM_BE`  out  4  byte-lane write mask, active high
- `MEM_DI`  out  32  SRAM write data
- `MEM_DOUT`  in  32  SRAM read data, valid the cycle after the access

## Operation
- FSM states: IDLE, ACC1, ACC2, CAP, RESP. `REQ_READY` = (state == IDLE).
- On accept, latch the request and compute:
  - offset o = ADDR[1:0]
  - word w = ADDR[AWIDTH+1:2]
  - 8-bit lane mask m = {0001, 0011, 1111}[size] << o
  - 64-bit write image = WDATA << 8·o
  - split = |m[7:4]
- Range error when ADDR[31:AWIDTH+2] ≠ 0, or when split and w = 2^AWIDTH−1 (no wrap to word 0). An error request goes IDLE→RESP with RSP_ERR=1 and produces no SRAM access.
- ACC1: CSN=0, ADDR=w, BE=m[3:0], DI=image[31:0], WEN=~REQ_WE. Next state is ACC2 if split, else CAP for a load, else RESP.
- ACC2: CSN=0, ADDR=w+1, BE=m[7:4], DI=image[63:32]. For a load, capture MEM_DOUT into the low half. Next state is CAP for a load, else RESP.
- CAP: capture MEM_DOUT into the high half if split, otherwise into the low half. Next state is RESP.
- Load result = ({hi, lo} >> 8·o), truncated to size, sign-extended unless UNSIGNED.
- RESP: RSP_VALID=1 for one cycle, then IDLE. There is no response backpressure; the core must take the response.
- Outside ACC1/ACC2: CSN=1, WEN=1, BE=0; ADDR and DI hold their last values.
- Loads drive BE=m lanes as well; the SRAM ignores BE on reads.

## Timing
- All MEM_* and RSP_* outputs are registered. Accept cycle = T0.
- Latencies (cycle in which RSP_VALID is high):

  | Request | RSP_VALID |
  |---|---|
  | Store, single | T2 |
  | Store, split | T3 |
  | Load, single | T3 |
  | Load, split | T4 |
  | Error | T1 |

- Back-to-back: the next accept happens no earlier than the cycle after RESP. Throughput is 1 request per 3–5 cycles.
- Reset values, applied asynchronously: state=IDLE, REQ_READY=1 once RST drops, CSN=1, WEN=1, BE=0, ADDR=0, DI=0, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0.
- Reset mid-operation:
  - The request is dropped and no RSP_VALID is issued.
  - A split store interrupted after ACC1 leaves its first word written. This is accepted behaviour.

## Structure
- Shared package `riscv_lsu_pkg` holds:
  - size encodings (SZ_B, SZ_H, SZ_W)
  - FSM state encoding
  - lane-mask constants
- Sub-module `dmem_lsu_align` (combinational) holds the write shift/mask generation and the read shift/extension. The top level contains the FSM, the request latch and the output registers.

## Test plan
Memory is zero-initialised, AWIDTH = 12.

1. Aligned store/load: SW 0xDEADBEEF @0x100.
   - T1: CSN=0, WEN=0, ADDR=0x040, BE=1111.
   - RSP_VALID at T2.
   - LW @0x100 returns 0xDEADBEEF with RSP_VALID at T3.
2. Extension, with word 0x040 = 0xDEADBEEF:
   - LB @0x101 → 0xFFFFFFBE
   - LBU @0x101 → 0x000000BE
   - LH @0x102 → 0xFFFFDEAD
   - LHU @0x102 → 0x0000DEAD
3. Split store/load: SW 0x11223344 @0x203.
   - T1: ADDR=0x080, BE=1000, DI=0x44000000.
   - T2: ADDR=0x081, BE=0111, DI=0x00112233.
   - RSP_VALID at T3.
   - LW @0x203 returns 0x11223344 with RSP_VALID at T4.
4. Range errors:
   - LW @0x4000 → RSP_VALID & RSP_ERR at T1, RDATA=0, CSN stays 1.
   - LW @0x3FFE (split at top word) → same error response.
5. Reset mid-split: raise RST during ACC2 of the case-3 store.
   - All outputs take reset values in the same cycle.
   - REQ_READY=1 after release, no RSP_VALID.
   - Word 0x080 reads 0x44000000; word 0x081 is unchanged.
6. Back-to-back: hold REQ_VALID high with SW then LW.
   - REQ_READY stays low from ACC1 through RESP.
   - The second request is accepted in the cycle after RESP and returns the stored value.
